cart_bus_master: RTL and testbench

- Bus initiator that drives the cartridge-side interface mappers respond to: cart_addr, cart_wr, cart_rd, cart_di out; cart_do in.
- Takes single-beat read/write requests over a valid/ready handshake and turns each into one cart bus cycle aligned to ce_cpu.
- Returns a one-cycle response pulse when the cycle completes.
- Used to replay mapper register writes and cart RAM contents during savestate/backup restore, and as the stimulus master in mapper benches.

---
 rtl/cart_bus_master.sv | 157 +++++++++++++++
 tb/tb_cart_bus_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_master.sv
// Single-beat request to cartridge bus cycle converter.
// All bus timing is counted in ce_cpu pulses.
module cart_bus_master #(
   parameter int SETUP_CE = 1,
   parameter int READ_CE  = 2,
   parameter int HOLD_CE  = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_cpu,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        busy,
   output logic [15:0] cart_addr,
   output logic        cart_wr,
   output logic        cart_rd,
   output logic [7:0]  cart_di,
   input  logic [7:0]  cart_do
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RESP
   } state_t;

   localparam logic [3:0] SETUP_N = 4'(SETUP_CE);
   localparam logic [3:0] READ_N  = 4'(READ_CE);
   localparam logic [3:0] HOLD_N  = 4'(HOLD_CE);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  di_q, di_d;
   logic [7:0]  rdat_q, rdat_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic        rsp_q, rsp_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      di_d        = di_q;
      rdat_d      = rdat_q;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               we_d    = req_we;
               addr_d  = req_addr;
               di_d    = req_wdata;
               cnt_d   = SETUP_N;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (ce_cpu) begin
               if (cnt_q == 4'd1) begin
                  state_d = STROBE;
                  cnt_d   = we_q ? 4'd1 : READ_N;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         STROBE: begin
            if (ce_cpu) begin
               if (cnt_q == 4'd1) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_N;
                  if (!we_q) rdat_d = cart_do;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         HOLD: begin
            if (ce_cpu) begin
               if (cnt_q == 4'd1) begin
                  state_d     = RESP;
                  cnt_d       = 4'd0;
                  rsp_rdata_d = we_q ? 8'h00 : rdat_q;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes and flags are decoded from the next state so they register cleanly.
      wr_d    = (state_d == STROBE) && we_q;
      rd_d    = (state_d == STROBE) && !we_q;
      rsp_d   = (state_d == RESP);
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 16'h0000;
         di_q        <= 8'h00;
         rdat_q      <= 8'h00;
         rsp_rdata_q <= 8'h00;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         rsp_q       <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         di_q        <= di_d;
         rdat_q      <= rdat_d;
         rsp_rdata_q <= rsp_rdata_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rsp_q       <= rsp_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = busy_q;
   assign cart_addr = addr_q;
   assign cart_di   = di_q;
   assign cart_wr   = wr_q;
   assign cart_rd   = rd_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Scoreboard bench for cart_bus_master: default-timing instance plus
// a second instance with SETUP_CE=3, READ_CE=1, HOLD_CE=2.
module tb_cart_bus_master;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ce_cpu = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic [7:0]  cart_do = '0;
   logic        sel = 1'b0;

   logic        rdy1, rsp1, busy1, wr1, rd1;
   logic [7:0]  rdat1, di1;
   logic [15:0] addr1;
   logic        rdy6, rsp6, busy6, wr6, rd6;
   logic [7:0]  rdat6, di6;
   logic [15:0] addr6;

   logic        v1, v6;
   logic        m_ready, m_rsp, m_busy, m_wr, m_rd;
   logic [7:0]  m_rdata, m_di;
   logic [15:0] m_addr;

   assign v1 = req_valid & ~sel;
   assign v6 = req_valid & sel;
   assign m_ready = sel ? rdy6 : rdy1;
   assign m_rsp   = sel ? rsp6 : rsp1;
   assign m_busy  = sel ? busy6 : busy1;
   assign m_wr    = sel ? wr6 : wr1;
   assign m_rd    = sel ? rd6 : rd1;
   assign m_rdata = sel ? rdat6 : rdat1;
   assign m_di    = sel ? di6 : di1;
   assign m_addr  = sel ? addr6 : addr1;

   cart_bus_master u_dut (
      .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu),
      .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp1), .rsp_rdata(rdat1), .busy(busy1),
      .cart_addr(addr1), .cart_wr(wr1), .cart_rd(rd1),
      .cart_di(di1), .cart_do(cart_do)
   );

   cart_bus_master #(.SETUP_CE(3), .READ_CE(1), .HOLD_CE(2)) u_dut6 (
      .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu),
      .req_valid(v6), .req_ready(rdy6), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp6), .rsp_rdata(rdat6), .busy(busy6),
      .cart_addr(addr6), .cart_wr(wr6), .cart_rd(rd6),
      .cart_di(di6), .cart_do(cart_do)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errs = 0;
   int cyc = 0;
   int ce_mode = 0;
   int excl_bad = 0;
   int rsp_cnt = 0;
   logic [7:0]  exp_q[$];
   logic [23:0] wr_log[$];
   logic        wr_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   // ce_cpu changes just after the edge so it is stable at negedge and next posedge.
   initial begin
      forever begin
         @(posedge clk_sys);
         #2;
         case (ce_mode)
            0: ce_cpu = 1'b1;
            1: ce_cpu = (cyc % 4 == 0);
            default: ce_cpu = 1'b0;
         endcase
      end
   end

   always @(negedge clk_sys) begin
      if (m_wr && m_rd) excl_bad++;
      if (m_wr && !wr_prev) wr_log.push_back({m_addr, m_di});
      wr_prev <= m_wr;
      if (!reset && m_rsp) begin
         rsp_cnt++;
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
         end else begin
            check("rsp_rdata", {24'h0, m_rdata}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic xfer(input logic we, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] cdo,
                       input int e_pre, input int e_str, input int e_hold,
                       output int scyc, output int lat);
      int pre, str, hold, n, c0;
      logic bad_addr, bad_strb;
      pre = 0; str = 0; hold = 0; n = 0; scyc = 0;
      bad_addr = 0; bad_strb = 0;
      @(negedge clk_sys);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      cart_do = cdo;
      while (!m_ready && n < 400) begin @(negedge clk_sys); n++; end
      @(posedge clk_sys);
      exp_q.push_back(we ? 8'h00 : cdo);
      @(negedge clk_sys);
      req_valid = 1'b0;
      req_addr = 16'($urandom);
      req_wdata = 8'($urandom);
      c0 = cyc;
      while (!(m_wr || m_rd) && n < 400) begin
         if (ce_cpu) pre++;
         if (m_addr !== a || m_di !== d) bad_addr = 1;
         @(negedge clk_sys); n++;
      end
      while ((m_wr || m_rd) && n < 400) begin
         if (ce_cpu) str++;
         scyc++;
         if (we ? m_rd : m_wr) bad_strb = 1;
         if (m_addr !== a || m_di !== d) bad_addr = 1;
         @(negedge clk_sys); n++;
      end
      while (!m_rsp && n < 400) begin
         if (ce_cpu) hold++;
         if (m_wr || m_rd) bad_strb = 1;
         if (m_addr !== a || m_di !== d) bad_addr = 1;
         @(negedge clk_sys); n++;
      end
      lat = cyc - c0;
      check("xfer_timeout", (n >= 400) ? 1 : 0, 0);
      check("setup_ce", pre, e_pre);
      check("strobe_ce", str, e_str);
      check("hold_ce", hold, e_hold);
      check("addr_stable", bad_addr, 0);
      check("strobe_kind", bad_strb, 0);
      @(negedge clk_sys);
      cart_do = 8'h00;
   endtask

   initial begin
      int scyc, lat, n, r0;
      logic bad;

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_ready", m_ready, 1);
      check("rst_busy", m_busy, 0);
      check("rst_addr", m_addr, 0);
      check("rst_strobes", {m_wr, m_rd, m_rsp}, 0);
      check("rst_rdata", m_rdata, 0);
      reset = 1'b0;

      // 1: write with ce every 4th clock
      ce_mode = 1;
      xfer(1'b1, 16'h2100, 8'h05, 8'hEE, 1, 1, 1, scyc, lat);

      // 2: read with ce continuously high
      ce_mode = 0;
      repeat (3) @(negedge clk_sys);
      xfer(1'b0, 16'hA1FF, 8'h00, 8'hF7, 1, 2, 1, scyc, lat);
      check("rd_cycles", scyc, 2);
      check("rd_latency", lat, 4);
      repeat (3) @(negedge clk_sys);
      check("rdata_held", m_rdata, 8'hF7);

      // 3: back-to-back writes with req_valid held
      wr_log.delete();
      r0 = rsp_cnt;
      @(negedge clk_sys);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0000; req_wdata = 8'h0A;
      check("b2b_ready0", m_ready, 1);
      @(posedge clk_sys);
      exp_q.push_back(8'h00);
      @(negedge clk_sys);
      req_addr = 16'h2100; req_wdata = 8'h03;
      n = 0; bad = 0;
      while (!m_ready && n < 400) begin
         if (!m_busy) bad = 1;
         @(negedge clk_sys); n++;
      end
      check("b2b_busy", bad, 0);
      check("b2b_timeout", (n >= 400) ? 1 : 0, 0);
      @(posedge clk_sys);
      exp_q.push_back(8'h00);
      @(negedge clk_sys);
      req_valid = 1'b0;
      check("b2b_ready_busy", m_ready, 0);
      n = 0;
      while (m_busy && n < 400) begin @(negedge clk_sys); n++; end
      @(negedge clk_sys);
      check("b2b_nwr", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check("b2b_wr0", wr_log[0], 24'h00000A);
         check("b2b_wr1", wr_log[1], 24'h210003);
      end
      check("b2b_rsps", rsp_cnt - r0, 2);

      // 4: ce stall in SETUP
      ce_mode = 2;
      repeat (2) @(negedge clk_sys);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; cart_do = 8'h3C;
      @(posedge clk_sys);
      exp_q.push_back(8'h3C);
      @(negedge clk_sys);
      req_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (m_wr || m_rd || !m_busy || m_rsp) bad = 1;
         @(negedge clk_sys);
      end
      check("stall_hold", bad, 0);
      ce_mode = 0;
      n = 0;
      while (!m_rsp && n < 400) begin @(negedge clk_sys); n++; end
      check("stall_resume", m_rsp, 1);
      @(negedge clk_sys);
      cart_do = 8'h00;

      // 5: reset while cart_wr is high
      ce_mode = 1;
      @(negedge clk_sys);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4000; req_wdata = 8'h77;
      @(posedge clk_sys);
      exp_q.push_back(8'h00);
      @(negedge clk_sys);
      req_valid = 1'b0;
      n = 0;
      while (!m_wr && n < 400) begin @(negedge clk_sys); n++; end
      check("rst_mid_wr", m_wr, 1);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("rstm_wr", m_wr, 0);
      check("rstm_addr", m_addr, 0);
      check("rstm_ready", m_ready, 1);
      check("rstm_rsp", m_rsp, 0);
      reset = 1'b0;
      r0 = rsp_cnt;
      repeat (10) @(negedge clk_sys);
      check("rstm_no_rsp", rsp_cnt - r0, 0);
      xfer(1'b1, 16'h6000, 8'h99, 8'h00, 1, 1, 1, scyc, lat);

      // 6: alternate timing instance, read
      ce_mode = 0;
      sel = 1'b1;
      repeat (2) @(negedge clk_sys);
      xfer(1'b0, 16'hB00F, 8'h00, 8'h5C, 3, 1, 2, scyc, lat);
      check("p6_cycles", scyc, 1);
      check("p6_latency", lat, 6);
      sel = 1'b0;

      repeat (4) @(negedge clk_sys);
      check("sb_empty", exp_q.size(), 0);
      check("wr_rd_excl", excl_bad, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
